pixel_result_queue: RTL
=======================

Name: pixel_result_queue

Overview:
- Sits directly downstream of the Mandelbrot engine.
- Captures each finished result (pixel x, pixel y, iteration count) into a small FIFO and drives the engine's full_queue back-pressure input.
- Converts the iteration count to 24-bit RGB and presents pixels to the frame-buffer writer over a valid/ready stream.
- Counts completed pixels and pulses frame_done after the last pixel of a frame leaves.

Parameters:
PIXEL_DATA_WIDTH, 10, pixel coordinate width
ITERATIONS_WIDTH, 9, iteration count width (must be >= 8)
DEPTH, 8, FIFO storage entries (power of two, >= 2)
H_RES, 640, pixels per line
V_RES, 480, lines per frame

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-low
result_valid  in  1  one-cycle pulse: engine result is valid
iterations  in  ITERATIONS_WIDTH  engine iteration count
xpixel  in  PIXEL_DATA_WIDTH  engine pixel x
ypixel  in  PIXEL_DATA_WIDTH  engine pixel y
iterations_max  in  ITERATIONS_WIDTH  current iteration limit (in-set test)
full_queue  out  1  FIFO storage full; engine must not finish a pixel
out_valid  out  1  output pixel valid
out_ready  in  1  writer accepts output pixel
out_x  out  PIXEL_DATA_WIDTH  output pixel x
out_y  out  PIXEL_DATA_WIDTH  output pixel y
out_rgb  out  24  colour {R,G,B}
frame_done  out  1  one-cycle pulse when pixel (H_RES-1, V_RES-1) is accepted
overflow  out  1  sticky: a write was dropped

Behaviour:
Reset (reset low, async):
- Pointers, count, out_valid, full_queue, frame_done, overflow all cleared to 0.
- out_x, out_y, out_rgb reset to 0.
- Reset mid-transfer discards all queued pixels.

Storage:
- DEPTH-entry circular buffer holding {x, y, rgb}.
- Separate output register (out_*). Storage count excludes the output register.
- Pointers wrap modulo DEPTH.

Colour (combinational, at write time):
- iterations == iterations_max -> 24'h000000.
- Otherwise R = iterations[7:0], G = {iterations[6:0],1'b0}, B = {iterations[5:0],2'b00}.

Write:
- Accepted iff result_valid && count < DEPTH.
- If result_valid && count == DEPTH: result is dropped, overflow set until reset. A same-cycle pop does not rescue the write.

Bypass:
- If storage is empty and the output register is free (out_valid == 0, or out_valid && out_ready this cycle), an accepted write loads the output register directly.
- Latency in this case: result_valid at cycle t -> out_valid at t+1.

Pop:
- When the output register is free and count > 0, head loads into the output register and count decrements.
- A simultaneous accepted write goes to storage, so count is unchanged.

Output stream:
- out_valid stays high and out_* stay stable until out_ready is sampled high.
- Throughput is one pixel per cycle when out_ready is held high.

full_queue:
- Registered; equals (count == DEPTH) for the current cycle's state.
- Example: count = DEPTH-1 with a write and no pop -> full_queue = 1 on the next cycle.

Frame:
- frame_done pulses for one cycle, in the cycle after a transfer (out_valid && out_ready) with out_x == H_RES-1 && out_y == V_RES-1.
- No ordering is assumed; detection uses coordinates only.

Decomposition:
- Shared package mandelbrot_pkg holds:
  - ENGINE/PIXEL/ITERATIONS width constants
  - typedef pixel_result_t {x, y, rgb}
  - the iteration-to-RGB function
- One sub-module, result_fifo: parameterised DEPTH storage, pointers, count and full flag.
- Colour mapping, bypass logic, output register and frame detection stay in the top level.

Test Plan:
1. Reset released; one result_valid with x=5, y=7, iterations=20, iterations_max=255, out_ready=1 -> next cycle out_valid=1, out_x=5, out_y=7, out_rgb=24'h142850; out_valid=0 the following cycle.
2. iterations=255 == iterations_max=255 -> out_rgb=24'h000000.
3. out_ready=0; 9 back-to-back writes (DEPTH=8): first goes to the output register, next 8 fill storage, full_queue=1 one cycle after the 9th write. A 10th write -> dropped, overflow=1, count stays 8. Then out_ready=1 -> 9 pixels emerge in write order, full_queue deasserts one cycle after the first pop from storage.
4. Storage count=3, out_ready=1, result_valid every cycle for 10 cycles -> count stays 3, one pixel out per cycle, order preserved.
5. Accept pixel x=639, y=479 -> frame_done high for exactly one cycle after the transfer; x=639, y=478 -> no pulse.
6. Assert reset low mid-stream with count=4 -> out_valid=0, full_queue=0, overflow=0 immediately (async); after release, the next write emerges with 1-cycle latency.

Source files
------------

// File: rtl/mandelbrot_pkg.sv
// Shared definitions for the Mandelbrot pipeline.
// Holds the default datapath widths, the queued pixel record type, and the
// iteration-count to 24-bit RGB colour mapping used at the engine output.
package mandelbrot_pkg;

  localparam int unsigned ENGINE_DATA_W = 32;  // engine fixed-point word
  localparam int unsigned PIXEL_DATA_W  = 10;
  localparam int unsigned ITERATIONS_W  = 9;
  localparam int unsigned RGB_W         = 24;

  typedef struct packed {
    logic [PIXEL_DATA_W-1:0] x;
    logic [PIXEL_DATA_W-1:0] y;
    logic [RGB_W-1:0]        rgb;
  } pixel_result_t;

  // Points that hit the iteration limit are in the set and drawn black.
  // Otherwise the low count bits are spread across R, G and B at different
  // scales so neighbouring counts give visibly distinct hues.
  function automatic logic [RGB_W-1:0] iter_to_rgb(input logic [7:0] iter_lo,
                                                   input logic       in_set);
    if (in_set) begin
      return '0;
    end
    return {iter_lo, iter_lo[6:0], 1'b0, iter_lo[5:0], 2'b00};
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Circular buffer of queued pixel results.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   wr_en_i        push wr_data_i (caller guarantees not full)
//   wr_data_i      entry to store
//   rd_en_i        pop head (caller guarantees not empty)
//   rd_data_o      current head entry
//   empty_o        no entries stored
//   full_o         registered: DEPTH entries stored
module result_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 44
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             full_q;

  always_comb begin
    count_d = count_q;
    unique case ({wr_en_i, rd_en_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == FullCount);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign empty_o   = (count_q == '0);
  assign full_o    = full_q;

endmodule

// File: rtl/pixel_result_queue.sv
// Result queue between the Mandelbrot engine and the frame-buffer writer.
// Captures finished pixels, colours them, buffers them in a small FIFO with
// engine back-pressure, and streams them out over valid/ready.
// Ports:
//   clk, reset                       clock, asynchronous active-low reset
//   result_valid, iterations,        engine result pulse and payload
//   xpixel, ypixel, iterations_max   (limit used for the in-set test)
//   full_queue                       storage full, engine must stall
//   out_valid, out_ready, out_x,     output pixel stream
//   out_y, out_rgb
//   frame_done                       pulse after last pixel of frame leaves
//   overflow                         sticky: a result was dropped
module pixel_result_queue
  import mandelbrot_pkg::*;
#(
  parameter int unsigned PIXEL_DATA_WIDTH = 10,
  parameter int unsigned ITERATIONS_WIDTH = 9,
  parameter int unsigned DEPTH            = 8,
  parameter int unsigned H_RES            = 640,
  parameter int unsigned V_RES            = 480
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        result_valid,
  input  logic [ITERATIONS_WIDTH-1:0] iterations,
  input  logic [PIXEL_DATA_WIDTH-1:0] xpixel,
  input  logic [PIXEL_DATA_WIDTH-1:0] ypixel,
  input  logic [ITERATIONS_WIDTH-1:0] iterations_max,
  output logic                        full_queue,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PIXEL_DATA_WIDTH-1:0] out_x,
  output logic [PIXEL_DATA_WIDTH-1:0] out_y,
  output logic [RGB_W-1:0]            out_rgb,
  output logic                        frame_done,
  output logic                        overflow
);

  localparam int unsigned EntryW = 2 * PIXEL_DATA_WIDTH + RGB_W;
  localparam logic [PIXEL_DATA_WIDTH-1:0] XLast = PIXEL_DATA_WIDTH'(H_RES - 1);
  localparam logic [PIXEL_DATA_WIDTH-1:0] YLast = PIXEL_DATA_WIDTH'(V_RES - 1);

  logic [EntryW-1:0] wr_entry, head;
  logic              fifo_empty, fifo_full;
  logic              out_free, accept, bypass, pop, fifo_wr;

  assign wr_entry = {xpixel, ypixel,
                     iter_to_rgb(iterations[7:0], iterations == iterations_max)};

  // Output register can take a new pixel this cycle.
  assign out_free = !out_valid || out_ready;
  // A pop in the same cycle does not free a slot for a write into full storage.
  assign accept   = result_valid && !fifo_full;
  assign bypass   = accept && fifo_empty && out_free;
  assign pop      = out_free && !fifo_empty;
  assign fifo_wr  = accept && !bypass;

  result_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(EntryW)
  ) u_fifo (
    .clk_i    (clk),
    .rst_ni   (reset),
    .wr_en_i  (fifo_wr),
    .wr_data_i(wr_entry),
    .rd_en_i  (pop),
    .rd_data_o(head),
    .empty_o  (fifo_empty),
    .full_o   (fifo_full)
  );

  assign full_queue = fifo_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_rgb    <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (pop) begin
        out_valid                <= 1'b1;
        {out_x, out_y, out_rgb}  <= head;
      end else if (bypass) begin
        out_valid                <= 1'b1;
        {out_x, out_y, out_rgb}  <= wr_entry;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      overflow   <= overflow | (result_valid && fifo_full);
      frame_done <= out_valid && out_ready && (out_x == XLast) && (out_y == YLast);
    end
  end

endmodule
